// File: rtl/preg_alloc_ctrl_if.sv
// preg_alloc_ctrl_if: signal bundle between the rename-stage free-list controller and its
// neighbours (rename, retire lanes, free list queue, flush source).
//
// Modports:
//   slave  - the controller itself (preg_alloc_ctrl)
//   master - the surrounding pipeline / testbench that drives the controller inputs
//
// Signal summary:
//   flush, r_mapping            flush request and committed arch->phys map
//   stall, alloc_req            rename allocation request and stall
//   alloc_grant, alloc_preg     allocation result
//   free{0,1}_valid/_preg       retire-lane frees
//   free_ready                  retire lanes may present frees
//   fl_clear, fl_enque(_data)   free list queue clear / enqueue
//   fl_deque, fl_deque_data     free list queue dequeue and head
//   fl_empty, fl_full           free list queue status
//   recovering                  free list is being rebuilt after a flush
interface preg_alloc_ctrl_if #(
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned PREG_W    = 6
);
    logic                        flush;
    logic [NUM_AREGS*PREG_W-1:0] r_mapping;
    logic                        stall;
    logic                        alloc_req;
    logic                        alloc_grant;
    logic [PREG_W-1:0]           alloc_preg;
    logic                        free0_valid;
    logic [PREG_W-1:0]           free0_preg;
    logic                        free1_valid;
    logic [PREG_W-1:0]           free1_preg;
    logic                        free_ready;
    logic                        fl_clear;
    logic                        fl_enque;
    logic [PREG_W-1:0]           fl_enque_data;
    logic                        fl_deque;
    logic [PREG_W-1:0]           fl_deque_data;
    logic                        fl_empty;
    logic                        fl_full;
    logic                        recovering;

    modport master (
        output flush, r_mapping, stall, alloc_req,
        output free0_valid, free0_preg, free1_valid, free1_preg,
        output fl_deque_data, fl_empty, fl_full,
        input  alloc_grant, alloc_preg, free_ready,
        input  fl_clear, fl_enque, fl_enque_data, fl_deque, recovering
    );

    modport slave (
        input  flush, r_mapping, stall, alloc_req,
        input  free0_valid, free0_preg, free1_valid, free1_preg,
        input  fl_deque_data, fl_empty, fl_full,
        output alloc_grant, alloc_preg, free_ready,
        output fl_clear, fl_enque, fl_enque_data, fl_deque, recovering
    );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// preg_alloc_ctrl: physical-register free list controller for the rename stage.
//
// - Grants rename allocations by dequeuing the free list head (combinational).
// - Merges the two retire-lane frees into the queue's single enqueue port through a small
//   pending FIFO, draining one entry per cycle.
// - On flush, clears the queue and rebuilds it by scanning every physical register index and
//   enqueuing those not present in the committed map, one per cycle.
//
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    preg_alloc_ctrl_if slave modport (see interface file for signal list)
//
// NUM_PREGS must equal 2**PREG_W and PEND_DEPTH must be >= 2.
module preg_alloc_ctrl #(
    parameter int unsigned NUM_PREGS  = 64,
    parameter int unsigned NUM_AREGS  = 32,
    parameter int unsigned PREG_W     = 6,
    parameter int unsigned PEND_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    preg_alloc_ctrl_if.slave  bus
);
    localparam int unsigned PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(PEND_DEPTH + 1);

    localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(PEND_DEPTH - 2);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PEND_DEPTH - 1);
    localparam logic [PREG_W-1:0] IDX_LAST  = PREG_W'(NUM_PREGS - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StClear = 2'd1,
        StScan  = 2'd2
    } state_e;

    // Architectural state.
    state_e                state_q, state_d;
    logic [NUM_PREGS-1:0]  used_q, used_d;
    logic [PREG_W-1:0]     idx_q, idx_d;
    logic [PREG_W-1:0]     pend_mem_q [PEND_DEPTH];
    logic [PREG_W-1:0]     pend_mem_d [PEND_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      pend_count_q, pend_count_d;
    logic                  fl_clear_q, fl_clear_d;
    logic                  recovering_q, recovering_d;

    // Combinational helpers.
    logic                  in_run;
    logic                  grant;
    logic                  free_ready;
    logic                  accept;
    logic                  push0;
    logic                  push1;
    logic                  drain;
    logic [PTR_W-1:0]      wr_ptr_tmp;
    logic [NUM_PREGS-1:0]  used_map;
    logic                  enq;
    logic [PREG_W-1:0]     enq_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Allocation: no grant outside RUN or in a flush cycle, so a register
    // handed out can never collide with the rebuilt list.
    // ------------------------------------------------------------------
    assign in_run = (state_q == StRun);
    assign grant  = bus.alloc_req & ~bus.stall & ~bus.fl_empty & in_run & ~bus.flush;

    assign bus.alloc_grant = grant;
    assign bus.fl_deque    = grant;
    assign bus.alloc_preg  = grant ? bus.fl_deque_data : '0;

    // ------------------------------------------------------------------
    // Pending free FIFO. Ready leaves room for two pushes in the same cycle.
    // Flush-cycle frees are dropped: the committed map already covers them.
    // ------------------------------------------------------------------
    assign free_ready = in_run & (pend_count_q <= READY_MAX);
    assign accept     = free_ready & ~bus.flush;
    assign push0      = accept & bus.free0_valid;
    assign push1      = accept & bus.free1_valid;
    assign drain      = in_run & (pend_count_q != '0) & ~bus.fl_full;

    assign bus.free_ready = free_ready;

    always_comb begin
        pend_mem_d   = pend_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pend_count_d = pend_count_q;
        wr_ptr_tmp   = wr_ptr_q;
        if (state_q == StClear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            pend_count_d = '0;
        end else begin
            // Lane 0 is written ahead of lane 1 so retire order is preserved.
            if (push0) begin
                pend_mem_d[wr_ptr_tmp] = bus.free0_preg;
                wr_ptr_tmp             = ptr_inc(wr_ptr_tmp);
            end
            if (push1) begin
                pend_mem_d[wr_ptr_tmp] = bus.free1_preg;
                wr_ptr_tmp             = ptr_inc(wr_ptr_tmp);
            end
            wr_ptr_d = wr_ptr_tmp;
            if (drain) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            pend_count_d = pend_count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(drain);
        end
    end

    // ------------------------------------------------------------------
    // Used bitmap from the committed map: every mapped preg is in use.
    // ------------------------------------------------------------------
    always_comb begin
        used_map = '0;
        for (int i = 0; i < int'(NUM_AREGS); i++) begin
            used_map[bus.r_mapping[i*PREG_W +: PREG_W]] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Recovery FSM and enqueue port ownership (drain in RUN, scan in SCAN).
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        used_d   = used_q;
        enq      = 1'b0;
        enq_data = '0;
        case (state_q)
            StRun: begin
                if (drain) begin
                    enq      = 1'b1;
                    enq_data = pend_mem_q[rd_ptr_q];
                end
                if (bus.flush) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                used_d  = used_map;
                idx_d   = '0;
                state_d = bus.flush ? StClear : StScan;
            end
            StScan: begin
                if (!used_q[idx_q]) begin
                    enq      = 1'b1;
                    enq_data = idx_q;
                end
                if (bus.flush) begin
                    state_d = StClear;
                end else if (!bus.fl_full) begin
                    // A full queue holds the scan position until space returns.
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
        fl_clear_d   = (state_d == StClear);
        recovering_d = (state_d != StRun);
    end

    assign bus.fl_enque      = enq;
    assign bus.fl_enque_data = enq_data;
    assign bus.fl_clear      = fl_clear_q;
    assign bus.recovering    = recovering_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            used_q       <= '0;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_count_q <= '0;
            fl_clear_q   <= 1'b0;
            recovering_q <= 1'b0;
            for (int i = 0; i < int'(PEND_DEPTH); i++) begin
                pend_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            used_q       <= used_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_count_q <= pend_count_d;
            fl_clear_q   <= fl_clear_d;
            recovering_q <= recovering_d;
            for (int i = 0; i < int'(PEND_DEPTH); i++) begin
                pend_mem_q[i] <= pend_mem_d[i];
            end
        end
    end

endmodule
